io_interface: RTL and testbench

IO_INTERFACE -- requirements
Module: io_interface

---
 rtl/io_pkg.sv | 12 +
 rtl/io_interface_if.sv | 23 ++
 rtl/io_byte_fifo.sv | 59 +++++
 rtl/io_interface.sv | 108 ++++++++++
 tb/tb_io_interface.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and constants for the io_interface block
package io_pkg;

    localparam int DATA_W           = 8;
    localparam int IN_DEPTH_DEFAULT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_t;

endpackage

// File: rtl/io_interface_if.sv
// rtl/io_interface_if.sv - keyboard-side push and printer-side pop byte handshakes
interface io_interface_if;

    logic                       in_valid;
    logic [io_pkg::DATA_W-1:0]  in_data;
    logic                       in_ready;
    logic                       out_valid;
    logic [io_pkg::DATA_W-1:0]  out_data;
    logic                       out_ready;

    // External devices: keyboard pushes bytes, printer pops them
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The io_interface block itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/io_byte_fifo.sv
// rtl/io_byte_fifo.sv - small input byte buffer feeding INPR
module io_byte_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = IN_DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full buffer refuses pushes even when a pop frees a slot this cycle
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage, wrapping pointers (DEPTH is a power of two) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_interface.sv
// rtl/io_interface.sv - INPR/OUTR device interface with flags and interrupt request
module io_interface
    import io_pkg::*;
#(
    parameter int IN_DEPTH = IN_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    io_interface_if.slave       bus,
    output logic [DATA_W-1:0]   inpr_outdata,
    input  logic                inp_clr,
    input  logic                out_load,
    input  logic [DATA_W-1:0]   ac_low,
    input  logic                ien_set,
    input  logic                ien_clr,
    input  logic                irq_ack,
    output logic                fgi,
    output logic                fgo,
    output logic                ien,
    output logic                irq
);

    logic [$clog2(IN_DEPTH):0] count;
    logic                      full;
    logic                      empty;
    out_state_t                state;
    out_state_t                state_n;
    logic                      load_en;
    logic                      send_valid;
    logic [DATA_W-1:0]         out_data_q;

    io_byte_fifo #(
        .DEPTH (IN_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .pop   (inp_clr),
        .wdata (bus.in_data),
        .head  (inpr_outdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready  = ~full;
    assign fgi           = (count != '0);
    assign bus.out_valid = send_valid;
    assign bus.out_data  = out_data_q;

    // Output FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Output FSM: OUTR is only loadable while idle, held until the printer takes it
    always_comb begin
        state_n    = state;
        fgo        = 1'b0;
        send_valid = 1'b0;
        load_en    = 1'b0;
        case (state)
            IDLE: begin
                fgo = 1'b1;
                if (out_load) begin
                    load_en = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                send_valid = 1'b1;
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // OUTR holding register, frozen for the whole SEND phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else if (load_en) begin
            out_data_q <= ac_low;
        end
    end

    // Interrupt enable (clear beats set) and registered interrupt request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ien <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (ien_clr || irq_ack) begin
                ien <= 1'b0;
            end else if (ien_set) begin
                ien <= 1'b1;
            end
            irq <= ien & (~empty | fgo);
        end
    end

endmodule

// File: tb/tb_io_interface.sv
// tb/tb_io_interface.sv - scoreboard bench for io_interface
module tb_io_interface;
    import io_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inp_clr = 1'b0;
    logic       out_load = 1'b0;
    logic [7:0] ac_low = 8'h00;
    logic       ien_set = 1'b0;
    logic       ien_clr = 1'b0;
    logic       irq_ack = 1'b0;
    logic [7:0] inpr_outdata;
    logic       fgi, fgo, ien, irq;

    io_interface_if bus();

    io_interface #(.IN_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .inpr_outdata (inpr_outdata),
        .inp_clr      (inp_clr),
        .out_load     (out_load),
        .ac_low       (ac_low),
        .ien_set      (ien_set),
        .ien_clr      (ien_clr),
        .irq_ack      (irq_ack),
        .fgi          (fgi),
        .fgo          (fgo),
        .ien          (ien),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    bit         m_send = 0;
    bit         m_ien = 0;
    bit         m_irq = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check_val("rst_fgi", fgi, 0);
        check_val("rst_inpr", inpr_outdata, 8'h00);
        check_val("rst_in_ready", bus.in_ready, 1);
        check_val("rst_fgo", fgo, 1);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_out_data", bus.out_data, 8'h00);
        check_val("rst_ien", ien, 0);
        check_val("rst_irq", irq, 0);
    endtask

    // One clock: check outputs against the model, advance the model across the edge
    task automatic step();
        bit         m_fgi, m_fgo, push, pop, fire, load, n_ien, n_irq;
        logic [7:0] d, a;
        m_fgi = (in_q.size() != 0);
        m_fgo = !m_send;
        check_val("fgi", fgi, m_fgi);
        check_val("fgo", fgo, m_fgo);
        check_val("in_ready", bus.in_ready, in_q.size() != DEPTH);
        check_val("out_valid", bus.out_valid, m_send);
        check_val("ien", ien, m_ien);
        check_val("irq", irq, m_irq);
        if (m_fgi) check_val("inpr_head", inpr_outdata, in_q[0]);
        if (m_send) check_val("out_data", bus.out_data, out_q[0]);
        d     = bus.in_data;
        a     = ac_low;
        push  = bus.in_valid && (in_q.size() != DEPTH);
        pop   = inp_clr && m_fgi;
        fire  = m_send && bus.out_ready;
        load  = !m_send && out_load;
        n_irq = m_ien && (m_fgi || m_fgo);
        n_ien = (ien_clr || irq_ack) ? 1'b0 : (ien_set ? 1'b1 : m_ien);
        @(posedge clk);
        #1;
        if (pop) void'(in_q.pop_front());
        if (push) in_q.push_back(d);
        if (fire) begin
            void'(out_q.pop_front());
            m_send = 0;
        end
        if (load) begin
            out_q.push_back(a);
            m_send = 1;
        end
        m_ien = n_ien;
        m_irq = n_irq;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Single byte through INPR
        bus.in_valid = 1'b1; bus.in_data = 8'h41;
        step();
        bus.in_valid = 1'b0;
        check_val("req028_fgi", fgi, 1);
        check_val("req028_inpr", inpr_outdata, 8'h41);
        inp_clr = 1'b1;
        step();
        inp_clr = 1'b0;
        check_val("req028_fgi_clr", fgi, 0);
        check_val("req028_ready", bus.in_ready, 1);
        step();

        // Fill, then push-while-full with a simultaneous pop
        bus.in_valid = 1'b1; bus.in_data = 8'h10;
        step();
        bus.in_data = 8'h20;
        step();
        check_val("req029_full", bus.in_ready, 0);
        bus.in_data = 8'h30; inp_clr = 1'b1;
        step();
        inp_clr = 1'b0;
        check_val("req029_head", inpr_outdata, 8'h20);
        check_val("req029_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check_val("req029_full2", bus.in_ready, 0);
        inp_clr = 1'b1;
        step();
        step();
        inp_clr = 1'b0;
        step();

        // OUTR load, ignored reload during SEND, then printer accepts
        ac_low = 8'h5A; out_load = 1'b1;
        step();
        check_val("req030_data", bus.out_data, 8'h5A);
        ac_low = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        out_load = 1'b0;
        check_val("req030_hold", bus.out_data, 8'h5A);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val("req030_fgo", fgo, 1);
        check_val("req030_valid", bus.out_valid, 0);
        step();

        // Interrupt enable priority and request timing
        ien_set = 1'b1; ien_clr = 1'b1;
        step();
        ien_clr = 1'b0;
        check_val("req031_clr_wins", ien, 0);
        step();
        ien_set = 1'b0;
        step();
        check_val("req031_irq", irq, 1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_val("req031_ack_ien", ien, 0);
        step();
        check_val("req031_ack_irq", irq, 0);
        step();

        // Asynchronous reset in the middle of a SEND with a byte buffered
        ien_set = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h66;
        step();
        ien_set = 1'b0;
        bus.in_valid = 1'b0; ac_low = 8'h77; out_load = 1'b1;
        step();
        out_load = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        in_q.delete();
        out_q.delete();
        m_send = 0; m_ien = 0; m_irq = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = $urandom_range(0, 1);
            bus.in_data   = 8'($urandom);
            inp_clr       = ($urandom_range(0, 2) == 0);
            out_load      = ($urandom_range(0, 2) == 0);
            ac_low        = 8'($urandom);
            bus.out_ready = $urandom_range(0, 1);
            ien_set       = ($urandom_range(0, 4) == 0);
            ien_clr       = ($urandom_range(0, 9) == 0);
            irq_ack       = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
